// File: rtl/fan_pwm_pkg.sv
// Shared types and helpers for the multi-channel fan PWM controller.
package fan_pwm_pkg;

  typedef enum logic [1:0] {
    LOW  = 2'd1,
    MED  = 2'd2,
    HIGH = 2'd3
  } level_e;

  // Level encodes the quarter of full scale: LOW=1/4, MED=1/2, HIGH=3/4.
  function automatic logic [31:0] level_to_duty(input level_e level, input int unsigned cnt_w);
    return {30'd0, level} << (cnt_w - 2);
  endfunction

  // Moves duty toward target by at most step. Comparing the distance against
  // the step keeps the arithmetic free of overflow or underflow.
  function automatic logic [31:0] ramp_step(input logic [31:0] duty,
                                            input logic [31:0] target,
                                            input logic [31:0] step);
    logic [31:0] r;
    r = duty;
    if (duty < target) begin
      r = ((target - duty) > step) ? (duty + step) : target;
    end else if (duty > target) begin
      r = ((duty - target) > step) ? (duty - step) : target;
    end
    return r;
  endfunction

endpackage

// File: rtl/fan_pwm_chan.sv
// One fan channel: hysteretic level FSM, boundary-gated duty ramp and PWM flop.
module fan_pwm_chan
  import fan_pwm_pkg::*;
#(
  parameter int CNT_W     = 10,
  parameter int TEMP_W    = 8,
  parameter int T_LO      = 50,
  parameter int T_HI      = 70,
  parameter int HYST      = 2,
  parameter int RAMP_STEP = 64
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [CNT_W-1:0]  cnt,
  input  logic              bnd,
  input  logic [TEMP_W-1:0] temp,
  input  logic              en,
  input  logic              force_max,
  output logic              pwm,
  output logic [CNT_W-1:0]  duty,
  output logic [1:0]        fan_speed,
  output logic              at_target
);

  localparam logic [TEMP_W-1:0] T_LO_V = TEMP_W'(T_LO);
  localparam logic [TEMP_W-1:0] T_HI_V = TEMP_W'(T_HI);
  localparam logic [TEMP_W-1:0] T_LO_H = T_LO_V - TEMP_W'(HYST);
  localparam logic [TEMP_W-1:0] T_HI_H = T_HI_V - TEMP_W'(HYST);

  level_e           lvl_q, lvl_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic             pwm_q, pwm_d;
  logic [CNT_W-1:0] target;

  always_comb begin
    lvl_d = lvl_q;
    case (lvl_q)
      LOW: begin
        if (temp > T_HI_V)       lvl_d = HIGH;
        else if (temp >= T_LO_V) lvl_d = MED;
      end
      MED: begin
        if (temp > T_HI_V)      lvl_d = HIGH;
        else if (temp < T_LO_H) lvl_d = LOW;
      end
      HIGH: begin
        if (temp < T_LO_H)       lvl_d = LOW;
        else if (temp <= T_HI_H) lvl_d = MED;
      end
      default: lvl_d = LOW;
    endcase
  end

  always_comb begin
    target = CNT_W'(level_to_duty(lvl_q, CNT_W));
    if (force_max) target = '1;
  end

  // Duty only moves at the period boundary so each period sees one duty value.
  always_comb begin
    duty_d = duty_q;
    if (bnd) begin
      duty_d = CNT_W'(ramp_step(32'(duty_q), 32'(target), 32'(RAMP_STEP)));
    end
    pwm_d = en & (cnt < duty_q);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      lvl_q  <= LOW;
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      lvl_q  <= lvl_d;
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm       = pwm_q;
  assign duty      = duty_q;
  assign fan_speed = lvl_q;
  assign at_target = (duty_q == target);

endmodule

// File: rtl/fan_pwm_ctrl.sv
// Multi-channel temperature-driven fan PWM controller: shared period counter
// plus one fan_pwm_chan per channel.
module fan_pwm_ctrl
  import fan_pwm_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int CNT_W     = 10,
  parameter int TEMP_W    = 8,
  parameter int T_LO      = 50,
  parameter int T_HI      = 70,
  parameter int HYST      = 2,
  parameter int RAMP_STEP = 64
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic [NCH-1:0][TEMP_W-1:0]  temp,
  input  logic [NCH-1:0]              en,
  input  logic                        force_max,
  output logic [NCH-1:0]              pwm,
  output logic [NCH-1:0][CNT_W-1:0]   duty,
  output logic [NCH-1:0][1:0]         fan_speed,
  output logic [NCH-1:0]              at_target,
  output logic                        period_start
);

  if (!(HYST <= T_LO && T_LO < T_HI)) begin : g_bad_thresholds
    $error("fan_pwm_ctrl: thresholds must satisfy HYST <= T_LO < T_HI");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             period_start_q, period_start_d;
  logic             bnd;

  assign bnd = (cnt_q == '1);

  // period_start carries the same one-cycle latency as pwm, so it lines up
  // with the first pwm-high cycle of every period.
  always_comb begin
    cnt_d          = cnt_q + 1'b1;
    period_start_d = (cnt_q == '0);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      period_start_q <= period_start_d;
    end
  end

  assign period_start = period_start_q;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    fan_pwm_chan #(
      .CNT_W    (CNT_W),
      .TEMP_W   (TEMP_W),
      .T_LO     (T_LO),
      .T_HI     (T_HI),
      .HYST     (HYST),
      .RAMP_STEP(RAMP_STEP)
    ) u_chan (
      .CLK      (CLK),
      .nRST     (nRST),
      .cnt      (cnt_q),
      .bnd      (bnd),
      .temp     (temp[i]),
      .en       (en[i]),
      .force_max(force_max),
      .pwm      (pwm[i]),
      .duty     (duty[i]),
      .fan_speed(fan_speed[i]),
      .at_target(at_target[i])
    );
  end

endmodule

// File: tb/tb_fan_pwm_ctrl.sv
// Directed bench for fan_pwm_ctrl: level table plus hand-written ramp, pwm,
// enable and reset sequences.
module tb_fan_pwm_ctrl;

  localparam int NCH    = 2;
  localparam int CNT_W  = 10;
  localparam int TEMP_W = 8;
  localparam int PERIOD = 1 << CNT_W;

  typedef struct {
    logic [TEMP_W-1:0] t;
    int                spd;
  } vec_t;

  logic                        CLK = 1'b0;
  logic                        nRST;
  logic [NCH-1:0][TEMP_W-1:0]  temp;
  logic [NCH-1:0]              en;
  logic                        force_max;
  logic [NCH-1:0]              pwm;
  logic [NCH-1:0][CNT_W-1:0]   duty;
  logic [NCH-1:0][1:0]         fan_speed;
  logic [NCH-1:0]              at_target;
  logic                        period_start;

  fan_pwm_ctrl dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .temp        (temp),
    .en          (en),
    .force_max   (force_max),
    .pwm         (pwm),
    .duty        (duty),
    .fan_speed   (fan_speed),
    .at_target   (at_target),
    .period_start(period_start)
  );

  // clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #600000;
    $display("FAIL watchdog: run did not finish act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  int n_chk = 0;
  int n_err = 0;
  int cnt   = 0;
  int tgt0  = 0;
  int d1    = 0;
  logic [CNT_W-1:0] exp_q[$];
  vec_t tbl[14];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s act=%0d exp=%0d (cnt=%0d)", name, act, exp, cnt);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge CLK);
    #1;
    cnt = (cnt + 1) % PERIOD;
  endtask

  task automatic goto_cnt(input int c);
    for (int k = 0; k < PERIOD && cnt != c; k++) step();
  endtask

  function automatic int ramp(input int d, input int t, input int s);
    if (d < t) return (d + s < t) ? d + s : t;
    if (d > t) return (d - s > t) ? d - s : t;
    return d;
  endfunction

  // Crosses the next period boundary and checks both channels' duty.
  task automatic next_bnd();
    int e0;
    int t1;
    step();
    goto_cnt(0);
    t1 = force_max ? 1023 : 256;
    d1 = ramp(d1, t1, 64);
    chk("exp_q_nonempty", int'(exp_q.size() > 0), 1);
    e0 = (exp_q.size() > 0) ? int'(exp_q.pop_front()) : 0;
    chk("duty0", int'(duty[0]), e0);
    chk("at_target0", int'(at_target[0]), int'(e0 == tgt0));
    chk("duty1", int'(duty[1]), d1);
    chk("at_target1", int'(at_target[1]), int'(d1 == t1));
    chk("period_start_cnt0", int'(period_start), 0);
  endtask

  task automatic measure(input int ch, output int hi, output int first, output int last);
    hi = 0; first = -1; last = -1;
    goto_cnt(0);
    for (int i = 1; i < PERIOD; i++) begin
      step();
      if (pwm[ch]) begin
        hi++;
        if (first < 0) first = cnt;
        last = cnt;
      end
    end
    next_bnd();
    chk("pwm_low_at_cnt0", int'(pwm[ch]), 0);
  endtask

  initial begin
    int hi, first, last;

    tbl[0]  = '{8'd49, 2};  // MED holds inside hysteresis band
    tbl[1]  = '{8'd48, 2};
    tbl[2]  = '{8'd47, 1};  // below T_LO-HYST
    tbl[3]  = '{8'd49, 1};  // LOW needs >= T_LO
    tbl[4]  = '{8'd50, 2};
    tbl[5]  = '{8'd70, 2};
    tbl[6]  = '{8'd71, 3};
    tbl[7]  = '{8'd69, 3};  // HIGH holds above T_HI-HYST
    tbl[8]  = '{8'd68, 2};
    tbl[9]  = '{8'd80, 3};
    tbl[10] = '{8'd47, 1};  // HIGH -> LOW skip
    tbl[11] = '{8'd80, 3};  // LOW -> HIGH skip
    tbl[12] = '{8'd48, 2};
    tbl[13] = '{8'd40, 1};

    // reset block
    nRST = 1'b0; temp = {8'd40, 8'd40}; en = 2'b11; force_max = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_duty", int'(duty), 0);
    chk("rst_pwm", int'(pwm), 0);
    chk("rst_speed0", int'(fan_speed[0]), 1);
    chk("rst_speed1", int'(fan_speed[1]), 1);
    chk("rst_at_target", int'(at_target), 0);
    chk("rst_period_start", int'(period_start), 0);
    @(negedge CLK);
    nRST = 1'b1;
    cnt = 0;

    // 1: ramp up from reset at LOW
    step();
    chk("ps_cnt1", int'(period_start), 1);
    chk("pwm_duty0", int'(pwm), 0);
    step();
    chk("ps_cnt2", int'(period_start), 0);
    goto_cnt(1023);
    chk("duty0_pre_bnd", int'(duty[0]), 0);
    tgt0 = 256;
    exp_q.push_back(10'd64); exp_q.push_back(10'd128);
    exp_q.push_back(10'd192); exp_q.push_back(10'd256);
    for (int i = 0; i < 4; i++) begin
      next_bnd();
      chk("speed0_low", int'(fan_speed[0]), 1);
    end

    // 2: LOW -> MED, ramp to 512, check pwm shape
    goto_cnt(100);
    temp[0] = 8'd60;
    chk("speed0_before", int'(fan_speed[0]), 1);
    step();
    chk("speed0_med", int'(fan_speed[0]), 2);
    chk("at_target0_med", int'(at_target[0]), 0);
    tgt0 = 512;
    exp_q.push_back(10'd320); exp_q.push_back(10'd384);
    exp_q.push_back(10'd448); exp_q.push_back(10'd512);
    for (int i = 0; i < 4; i++) next_bnd();
    exp_q.push_back(10'd512);
    measure(0, hi, first, last);
    chk("pwm512_high", hi, 512);
    chk("pwm512_first", first, 1);
    chk("pwm512_last", last, 512);

    // 3: hysteresis table on channel 0
    foreach (tbl[i]) begin
      temp[0] = tbl[i].t;
      step();
      chk($sformatf("lvl_tbl%0d_t%0d", i, tbl[i].t), int'(fan_speed[0]), tbl[i].spd);
    end
    chk("speed1_untouched", int'(fan_speed[1]), 1);
    tgt0 = 256;
    exp_q.push_back(10'd448); exp_q.push_back(10'd384);
    exp_q.push_back(10'd320); exp_q.push_back(10'd256);
    for (int i = 0; i < 4; i++) next_bnd();

    // 4: LOW -> HIGH directly, then force_max mid-ramp
    goto_cnt(50);
    temp[0] = 8'd80;
    step();
    chk("speed0_high", int'(fan_speed[0]), 3);
    chk("at_target0_768", int'(at_target[0]), 0);
    tgt0 = 768;
    exp_q.push_back(10'd320); exp_q.push_back(10'd384);
    for (int i = 0; i < 2; i++) next_bnd();
    goto_cnt(200);
    force_max = 1'b1;
    step();
    chk("at_target0_force", int'(at_target[0]), 0);
    chk("at_target1_force", int'(at_target[1]), 0);
    tgt0 = 1023;
    for (int v = 448; v <= 960; v += 64) exp_q.push_back(CNT_W'(v));
    exp_q.push_back(10'd1023);
    for (int i = 0; i < 10; i++) next_bnd();
    chk("duty0_full", int'(duty[0]), 1023);
    exp_q.push_back(10'd1023);
    measure(0, hi, first, last);
    chk("pwm_full_high", hi, 1023);
    chk("pwm_full_first", first, 1);

    // 5: enable gating while the ramp continues
    force_max = 1'b0;
    tgt0 = 768;
    goto_cnt(500);
    en = 2'b10;
    step();
    chk("pwm0_disabled", int'(pwm[0]), 0);
    chk("pwm1_enabled", int'(pwm[1]), int'(500 < d1));
    exp_q.push_back(10'd959);
    next_bnd();
    goto_cnt(10);
    chk("pwm0_still_off", int'(pwm[0]), 0);
    en = 2'b11;
    step();
    chk("pwm0_resumed", int'(pwm[0]), 1);

    // 6: asynchronous reset mid-ramp
    goto_cnt(300);
    #2;
    nRST = 1'b0;
    #1;
    chk("arst_duty", int'(duty), 0);
    chk("arst_pwm", int'(pwm), 0);
    chk("arst_speed0", int'(fan_speed[0]), 1);
    chk("arst_speed1", int'(fan_speed[1]), 1);
    chk("arst_at_target", int'(at_target), 0);
    chk("arst_period_start", int'(period_start), 0);
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    cnt = 0; d1 = 0; tgt0 = 768;
    exp_q.delete();
    step();
    chk("post_rst_speed0", int'(fan_speed[0]), 3);
    chk("post_rst_ps", int'(period_start), 1);
    exp_q.push_back(10'd64); exp_q.push_back(10'd128);
    for (int i = 0; i < 2; i++) next_bnd();

    // final report
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
